// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its storage array.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write port, synchronous registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage is deliberately left out of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO (legacy name): wrap-bit pointers, full/empty flags, registered read data.
module async_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic                wr_ok;
    logic                rd_ok;

    // The extra MSB distinguishes a full ring from an empty one when the indices match.
    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                    (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    assign wr_ok = wen && !wfull && !rst;
    assign rd_ok = ren && !rempty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ok),
        .waddr(wptr[ADDR_WIDTH-1:0]),
        .wdata(wdata),
        .re   (rd_ok),
        .raddr(rptr[ADDR_WIDTH-1:0]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Directed and randomized checks of async_fifo against a queue-based reference model.
module tb_async_fifo;

    logic       clk;
    logic       rst;
    logic       wen;
    logic [7:0] wdata;
    logic       wfull;
    logic       ren;
    logic [7:0] rdata;
    logic       rempty;

    int         total;
    int         passed;
    string      phase;
    logic [7:0] q[$];
    logic [7:0] rdata_m;

    async_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .wdata (wdata),
        .wfull (wfull),
        .ren   (ren),
        .rdata (rdata),
        .rempty(rempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    endtask

    // Drive one cycle, advance the reference model across the edge, then compare.
    task automatic cycle(input logic r, input logic w, input logic [7:0] d, input logic rd);
        bit wok;
        bit rok;
        rst   = r;
        wen   = w;
        wdata = d;
        ren   = rd;
        @(posedge clk);
        if (r) begin
            q.delete();
            rdata_m = 8'h00;
        end else begin
            wok = w && (q.size() < 16);
            rok = rd && (q.size() > 0);
            if (rok) rdata_m = q.pop_front();
            if (wok) q.push_back(d);
        end
        #1;
        check("rempty", 32'(rempty), 32'(q.size() == 0));
        check("wfull",  32'(wfull),  32'(q.size() == 16));
        check("rdata",  32'(rdata),  32'(rdata_m));
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        rdata_m = 8'h00;
        rst     = 1'b0;
        wen     = 1'b0;
        wdata   = 8'h00;
        ren     = 1'b0;

        phase = "reset";
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'h55, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        phase = "fill";
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);

        phase = "overflow";
        cycle(1'b0, 1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        phase = "drain";
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            check("drain_order", 32'(rdata), 32'(i));
        end

        phase = "underflow";
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("underflow_hold", 32'(rdata), 32'h0F);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        phase = "simul_empty";
        cycle(1'b0, 1'b1, 8'h77, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("no_fallthrough", 32'(rdata), 32'h77);

        phase = "wrap";
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("wrap_last", 32'(rdata), 32'h33);

        phase = "simul_full";
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        cycle(1'b0, 1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        phase = "mid_reset";
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("post_reset_data", 32'(rdata), 32'hC2);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 45));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
